mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the single-ported, one-cycle-read-latency `Memory` between two requesters: the processor and a secondary master such as a program loader or debug reader. It sits between the requesters and the RAM's `mem_addr`/`mem_rdata`/`mem_rstrb`/`mem_wdata`/`mem_wmask` interface. It serialises accesses through a three-state sequencer, arbitrates round-robin by default, and returns a one-cycle completion pulse to the winner.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; mask width is `DATA_W/8`.
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `p0_addr` / `p1_addr`  in  ADDR_W  requester byte address.
- `p0_wdata` / `p1_wdata`  in  DATA_W  write data.
- `p0_wmask` / `p1_wmask`  in  DATA_W/8  byte write enables; nonzero means write request.
- `p0_rstrb` / `p1_rstrb`  in  1  read request level.
- `p0_done` / `p1_done`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  shared read data, wired from `mem_rdata`; valid only while a `pN_done` is high.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_wmask`  out  DATA_W/8  RAM byte enables.
- `mem_rstrb`  out  1  RAM read strobe.
- `mem_rdata`  in  DATA_W  RAM read data, registered by RAM.
- `busy`  out  1  high in ISSUE and RESP.
- `grant`  out  1  index of current or last owner.

## Operation
- **Request:** port N requests when `pN_rstrb` is high or `pN_wmask` is nonzero. It holds addr, wdata, wmask and rstrb stable until its `pN_done`, then drops the request in the following cycle.
- **Write precedence:** if wmask is nonzero, the access is a write and `mem_rstrb` stays 0. Writes also pulse done.
- **FSM:** IDLE, ISSUE, RESP.
  - IDLE: if any request is present, select a winner, register its addr/wdata/wmask/rstrb and `grant`, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `mem_*` from the registers for exactly one cycle, then go to RESP.
  - RESP: `mem_wmask`=0 and `mem_rstrb`=0; assert `p[grant]_done`; `mem_rdata` is valid on `rdata`. Always go to IDLE.
- **Round-robin:** when both ports request in IDLE, the port that was not the last `grant` wins. After reset, the last grant is treated as port 1, so port 0 wins the first tie. A sole requester always wins.
- **Loser:** a losing request stays pending and is evaluated at the next IDLE.
- **Reset:** an asynchronous assertion at any time forces IDLE immediately.
  - All outputs clear: `mem_addr`/`mem_wdata`/`mem_wmask`/`mem_rstrb`=0, `p0_done`/`p1_done`=0, `busy`=0, `grant`=0.
  - An in-flight access is abandoned with no done pulse. A write is committed only if the ISSUE clock edge precedes the reset assertion.
- **Addresses:** passed through unmodified. No decode and no wrap handling.

## Timing
- Request visible in IDLE at cycle t → ISSUE at t+1 → RESP with `done` and valid `rdata` at t+2 → IDLE at t+3.
- Minimum access period is 3 cycles. Sustained throughput is 1 access per 3 cycles, alternating ports under contention.
- All `mem_*`, `done`, `busy` and `grant` outputs are registered. `rdata` is combinational from `mem_rdata`.
- `mem_wmask`/`mem_rstrb` are high for exactly one cycle per access.
- A request raised during ISSUE or RESP is first seen at the next IDLE.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - **Defined:** port 0 always wins a tie. Port 1 is served only when port 0 is idle in IDLE, so port 1 can starve.
  - **Undefined (default):** round-robin as described above.
- Only the winner selection changes. FSM and timing are identical in both modes.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/RESP);
  - port-index constants `PORT_CPU`=0 and `PORT_AUX`=1;
  - default `ADDR_W`/`DATA_W`.
- One sub-module, `rr_picker`: a two-request winner select taking `req[1:0]` and `last_grant` and producing `winner`, with the `MEM_ARB_FIXED_PRIO_EN` switch inside it.
- The FSM and output registers live in `mem_arbiter`.

## Test plan
- **Reset values:** hold resetn=0 → all outputs 0 and state IDLE. Release and idle for 5 cycles → no strobes.
- **Single read:** port 0 reads 0x0000_0010 at cycle t → `mem_rstrb`=1 and `mem_addr`=0x10 at t+1 only. `p0_done`=1 at t+2 with `rdata` equal to the RAM word; `p1_done` stays 0.
- **Write then read:** port 1 writes 0xDEADBEEF with mask 0xF at 0x20 → `mem_wmask`=0xF for one cycle and `mem_rstrb`=0. A subsequent port 0 read of 0x20 returns 0xDEADBEEF.
- **Contention:** both ports request continuously from reset → grants alternate 0,1,0,1, with a done every 3 cycles. With `MEM_ARB_FIXED_PRIO_EN` defined → every grant is 0.
- **Mid-operation reset:** assert resetn=0 during RESP → `done` drops immediately and outputs are 0. After release, a pending request is re-served from IDLE.
- **Partial write:** port 0 mask 0x2 with data 0x0000AB00 at 0x30 → only byte 1 changes on readback.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    // Access sequencer states: wait for a request, drive the RAM, return completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    // Requester indices; also the encoding of the grant output.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Default bus widths.
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-request winner select: round-robin by default, fixed port-0 priority with MEM_ARB_FIXED_PRIO_EN.
// Latency: purely combinational.
// Backpressure: none; a losing request simply remains asserted by its owner.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    // A sole requester always wins; only a tie depends on the selected policy.
    always_comb begin
        winner = PORT_CPU;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (req[PORT_AUX] && !req[PORT_CPU]) begin
            winner = PORT_AUX;
        end
`else
        if (req[PORT_AUX] && !req[PORT_CPU]) begin
            winner = PORT_AUX;
        end else if (req[PORT_AUX] && req[PORT_CPU]) begin
            winner = ~last_grant;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, 1-cycle-read-latency RAM between two requesters (config: MEM_ARB_FIXED_PRIO_EN).
// Latency: request seen in IDLE at t -> RAM strobe at t+1 -> pN_done with rdata at t+2; 3-cycle access period.
// Backpressure: requesters hold their request until pN_done; a losing request waits for the next IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    input  logic                p0_rstrb,
    output logic                p0_done,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    input  logic                p1_rstrb,
    output logic                p1_done,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_rstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                grant
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic                mem_rstrb_q, mem_rstrb_d;
    logic [1:0]          done_q, done_d;
    logic                busy_q, busy_d;
    logic                grant_q, grant_d;
    // Round-robin history; starts as port 1 so port 0 wins the first tie,
    // while the visible grant output still resets to 0.
    logic                last_q, last_d;

    logic [1:0]          req;
    logic                winner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [MASK_W-1:0]   sel_wmask;
    logic                sel_rstrb;

    assign req[PORT_CPU] = p0_rstrb | (|p0_wmask);
    assign req[PORT_AUX] = p1_rstrb | (|p1_wmask);

    rr_picker u_picker (
        .req        (req),
        .last_grant (last_q),
        .winner     (winner)
    );

    // Mux the winning requester's access onto the capture path.
    always_comb begin
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        sel_wmask = p0_wmask;
        sel_rstrb = p0_rstrb;
        if (winner == PORT_AUX) begin
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_wmask = p1_wmask;
            sel_rstrb = p1_rstrb;
        end
    end

    // Sequencer next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = '0;
        mem_rstrb_d = 1'b0;
        done_d      = 2'b00;
        busy_d      = 1'b0;
        grant_d     = grant_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_ISSUE;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_wmask_d = sel_wmask;
                    // A nonzero mask makes the access a write; never strobe a read with it.
                    mem_rstrb_d = sel_rstrb & ~(|sel_wmask);
                    busy_d      = 1'b1;
                    grant_d     = winner;
                    last_d      = winner;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                busy_d  = 1'b1;
                done_d  = (grant_q == PORT_AUX) ? 2'b10 : 2'b01;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_rstrb_q <= 1'b0;
            done_q      <= 2'b00;
            busy_q      <= 1'b0;
            grant_q     <= PORT_CPU;
            last_q      <= PORT_AUX;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_rstrb_q <= mem_rstrb_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_rstrb = mem_rstrb_q;
    assign p0_done   = done_q[PORT_CPU];
    assign p1_done   = done_q[PORT_AUX];
    assign busy      = busy_q;
    assign grant     = grant_q;
    // The RAM registers its read data, so it is already aligned with the done pulse.
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timing/memory model.
// Latency: n/a.
// Backpressure: requesters hold until done, then drop or immediately re-request.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_wmask[2];
    logic        p_rstrb[2];
    logic        p0_done, p1_done, busy, grant, mem_rstrb;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_addr   (p_addr[0]),
        .p0_wdata  (p_wdata[0]),
        .p0_wmask  (p_wmask[0]),
        .p0_rstrb  (p_rstrb[0]),
        .p0_done   (p0_done),
        .p1_addr   (p_addr[1]),
        .p1_wdata  (p_wdata[1]),
        .p1_wmask  (p_wmask[1]),
        .p1_rstrb  (p_rstrb[1]),
        .p1_done   (p1_done),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    // Behavioural single-port RAM with registered read data (16 words).
    logic [31:0] ram[16];
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= ram[mem_addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) ram[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    // Reference model: expected memory contents and one expected access timeline.
    logic [31:0] ref_mem[16];
    int          cyc, idle_cyc, issue_cyc;
    bit          in_reset, last, cur_grant;
    bit          ex_vld, ex_port, ex_wr;
    logic [31:0] ex_addr, ex_wdata, ex_rdata, last_rd;
    logic [3:0]  ex_wmask;
    int          pst[2];   // 0 idle, 1 requesting, 2 done seen
    int          gap[2];
    bit          auto_gen;
    int          b2b_pct;
    int          ndone[2];
    bit          dut_log[$];
    int          n_chk, n_fail;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic post(int p, bit wr, bit rs, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        p_addr[p]  = a;
        p_wdata[p] = d;
        p_wmask[p] = wr ? m : 4'h0;
        p_rstrb[p] = wr ? rs : 1'b1;
        pst[p]     = 1;
    endtask

    task automatic rand_post(int p);
        bit wr = bit'($urandom_range(0, 1));
        post(p, wr, bit'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
             $urandom, 4'($urandom_range(1, 15)));
    endtask

    task automatic clear_port(int p);
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
        p_wmask[p] = 4'h0;
        p_rstrb[p] = 1'b0;
        pst[p]     = 0;
        gap[p]     = $urandom_range(0, 4);
    endtask

    // Whenever the arbiter is free and someone asks, pick per the arbitration rule.
    task automatic model_decide();
        bit r0, r1, w;
        int idx;
        if (in_reset || cyc < idle_cyc) return;
        r0 = (pst[0] != 0);
        r1 = (pst[1] != 0);
        if (!(r0 || r1)) return;
        if (r0 && r1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = !last;
`endif
        end else begin
            w = r1;
        end
        idx      = int'(p_addr[w][5:2]);
        ex_vld   = 1'b1;
        ex_port  = w;
        ex_addr  = p_addr[w];
        ex_wdata = p_wdata[w];
        ex_wmask = p_wmask[w];
        ex_wr    = (p_wmask[w] != 4'h0);
        if (ex_wr) begin
            for (int b = 0; b < 4; b++)
                if (ex_wmask[b]) ref_mem[idx][b*8 +: 8] = ex_wdata[b*8 +: 8];
        end else begin
            ex_rdata = ref_mem[idx];
        end
        issue_cyc = cyc + 1;
        idle_cyc  = cyc + 3;
        last      = w;
    endtask

    // One clock: model decision on current inputs, edge, check outputs, requester update.
    task automatic step();
        bit          is_iss, is_rsp;
        bit          dn[2];
        logic [8:0]  exp_ctl;
        model_decide();
        @(posedge clk);
        cyc++;
        #1;
        is_iss = ex_vld && (cyc == issue_cyc);
        is_rsp = ex_vld && (cyc == issue_cyc + 1);
        if (is_iss) cur_grant = ex_port;
        exp_ctl = {is_rsp && ex_port, is_rsp && !ex_port, is_iss || is_rsp, cur_grant,
                   is_iss && !ex_wr, is_iss ? ex_wmask : 4'h0};
        chk("ctl", {p1_done, p0_done, busy, grant, mem_rstrb, mem_wmask}, exp_ctl);
        if (is_iss) begin
            chk("addr", mem_addr, ex_addr);
            if (ex_wr) chk("wdata", mem_wdata, ex_wdata);
        end
        if (is_rsp && !ex_wr) chk("rdata", rdata, ex_rdata);
        dn[0] = p0_done;
        dn[1] = p1_done;
        if (p0_done || p1_done) begin
            last_rd = rdata;
            dut_log.push_back(p1_done);
        end
        for (int p = 0; p < 2; p++) begin
            if (dn[p]) ndone[p]++;
            if (pst[p] == 2) begin
                if (auto_gen && $urandom_range(0, 99) < b2b_pct) rand_post(p);
                else clear_port(p);
            end else if (pst[p] == 0) begin
                if (auto_gen) begin
                    if (gap[p] == 0) rand_post(p);
                    else gap[p]--;
                end
            end else if (dn[p]) begin
                pst[p] = 2;
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic enter_reset();
        resetn    = 1'b0;
        in_reset  = 1'b1;
        ex_vld    = 1'b0;
        cur_grant = 1'b0;
    endtask

    task automatic leave_reset();
        resetn   = 1'b1;
        in_reset = 1'b0;
        idle_cyc = cyc;
        last     = 1'b1;
    endtask

    initial begin
        logic [31:0] old;
        int          base;
        bit          exp_pat[4];
        n_chk = 0; n_fail = 0; cyc = 0; idle_cyc = 0; issue_cyc = -10;
        auto_gen = 1'b0; b2b_pct = 0; last_rd = '0;
        ndone[0] = 0; ndone[1] = 0;
        for (int i = 0; i < 16; i++) begin
            old = $urandom;
            ram[i] = old;
            ref_mem[i] = old;
        end
        for (int p = 0; p < 2; p++) begin
            p_addr[p] = '0; p_wdata[p] = '0; p_wmask[p] = '0; p_rstrb[p] = 1'b0;
            pst[p] = 0; gap[p] = 0;
        end
        enter_reset();
        run(3);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'h0);
        leave_reset();
        run(5);

        // Single read from port 0.
        post(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        run(5);
        chk("rd_val", last_rd, ref_mem[4]);

        // Port 1 full write, then port 0 reads it back.
        post(1, 1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 4'hF);
        run(5);
        post(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        run(5);
        chk("wr_rd", last_rd, 32'hDEADBEEF);

        // Partial write of byte 1 only.
        old = ref_mem[12];
        post(0, 1'b1, 1'b1, 32'h30, 32'h0000AB00, 4'h2);
        run(5);
        post(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
        run(5);
        chk("partial", last_rd, {old[31:16], 8'hAB, old[7:0]});

        // Continuous contention from reset.
        enter_reset();
        run(2);
        auto_gen = 1'b1;
        b2b_pct  = 100;
        rand_post(0);
        rand_post(1);
        leave_reset();
        dut_log.delete();
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_pat = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        run(12);
        chk("n_grants", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            chk($sformatf("tie_grant%0d", i), dut_log[i], exp_pat[i]);

        // Randomized traffic with gaps and back-to-back requests.
        b2b_pct = 30;
        run(1500);
        auto_gen = 1'b0;
        run(20);

        // Reset asserted during RESP: done drops at once, request is re-served.
        post(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        run(1);
        @(posedge clk);
        cyc++;
        #1;
        chk("pre_rst_done", p0_done, 1'b1);
        enter_reset();
        #1;
        chk("mid_rst_ctl", {p1_done, p0_done, busy, grant, mem_rstrb, mem_wmask}, 9'h0);
        chk("mid_rst_bus", {mem_addr, mem_wdata}, 64'h0);
        run(2);
        base = ndone[0];
        leave_reset();
        run(5);
        chk("reserve", ndone[0], base + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
